// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a shared mux: registered one-hot gnt with matching sel/ene, owner held up to BURST cycles.
// Grant appears one cycle after req is sampled; no backpressure, and an owner's release takes effect at the next edge.
module rr_mux_arbiter #(
   parameter int bitNo = 4,
   parameter int selNo = $clog2(bitNo),
   parameter int BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [bitNo-1:0] req,
   output logic [bitNo-1:0] gnt,
   output logic [selNo-1:0] sel,
   output logic             ene,
   output logic             busy
);

   localparam int CW = $clog2(BURST) + 1;

   localparam logic [0:0]       IDLE     = 1'b0;
   localparam logic [0:0]       GRANT    = 1'b1;
   localparam logic [CW-1:0]    CNT_MAX  = CW'(BURST - 1);
   localparam logic [selNo-1:0] LAST_RST = selNo'(bitNo - 1);

   logic [0:0]       state;
   logic [selNo-1:0] last;
   logic [CW-1:0]    cnt;
   logic [selNo-1:0] pick;
   logic [bitNo-1:0] pick_oh;
   logic             any_req;
   logic             hold;

   // Pick the requester nearest above last, wrapping; the previous owner is farthest away.
   always_comb begin
      int best_d;
      int d;
      best_d = bitNo;
      d      = 0;
      pick   = last;
      for (int j = 0; j < bitNo; j++) begin
         d = (j - int'(last) - 1 + 2 * bitNo) % bitNo;
         if (req[j] && (d < best_d)) begin
            best_d = d;
            pick   = selNo'(j);
         end
      end
   end

   assign pick_oh = bitNo'(1) << pick;
   assign any_req = |req;
   assign hold    = req[sel] && (cnt < CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         sel   <= '0;
         ene   <= 1'b0;
         busy  <= 1'b0;
         cnt   <= '0;
         last  <= LAST_RST;
      end else begin
         case (state)
            GRANT: begin
               if (hold) begin
                  cnt <= cnt + 1'b1;
               end else if (any_req) begin
                  gnt  <= pick_oh;
                  sel  <= pick;
                  cnt  <= '0;
                  last <= pick;
               end else begin
                  state <= IDLE;
                  gnt   <= '0;
                  ene   <= 1'b0;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end
            end
            default: begin
               if (any_req) begin
                  state <= GRANT;
                  gnt   <= pick_oh;
                  sel   <= pick;
                  ene   <= 1'b1;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  last  <= pick;
               end else begin
                  gnt  <= '0;
                  ene  <= 1'b0;
                  busy <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 The block SHALL have parameter bitNo, default 4: number of requesters sharing one mux output; legal range 2..16.
REQ-002 The block SHALL have parameter selNo, default $clog2(bitNo): width of the select output.
REQ-003 The block SHALL have parameter BURST, default 4: maximum consecutive grant cycles per owner; legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 The block SHALL have port req, input, bitNo: request vector; bit i high means requester i wants the mux.
REQ-007 The block SHALL have port gnt, output, bitNo: registered one-hot grant, or all-zero.
REQ-008 The block SHALL have port sel, output, selNo: registered mux select; equals the index of the set gnt bit.
REQ-009 The block SHALL have port ene, output, 1: registered mux enable; high exactly when gnt is non-zero.
REQ-010 The block SHALL have port busy, output, 1: registered; high when the FSM is in GRANT.

Function
REQ-011 The block SHALL implement the FSM states IDLE and GRANT, plus a priority pointer last (selNo bits) and a burst counter cnt ($clog2(BURST)+1 bits).
REQ-012 The arbitration pick SHALL be the first set bit of req, searching upward from index last+1 modulo bitNo; the search SHALL wrap from bitNo-1 to 0.
REQ-013 IDLE: if req is non-zero, the block SHALL go to GRANT next cycle with gnt/sel set to the pick, ene=1, busy=1, cnt=0, last=pick.
REQ-014 IDLE: if req is zero, the block SHALL stay in IDLE with gnt=0, ene=0, and sel holding its previous value.
REQ-015 Grant latency SHALL be exactly 1 cycle: req sampled at edge t produces gnt visible after edge t.
REQ-016 GRANT hold: if req[sel]=1 and cnt<BURST-1, the block SHALL keep gnt/sel unchanged and increment cnt.
REQ-017 GRANT exit SHALL occur when req[sel]=0, or when cnt==BURST-1 at a sampling edge.
REQ-018 On GRANT exit with any req bit set, the block SHALL re-arbitrate per REQ-012 and hand off with no idle cycle: new gnt next cycle, cnt=0, last=new pick.
REQ-019 On GRANT exit, the current owner SHALL be re-granted only if it is the sole requester; its cnt SHALL restart at 0.
REQ-020 On GRANT exit with req=0, the block SHALL go to IDLE next cycle with gnt=0, ene=0, busy=0.
REQ-021 Release SHALL be registered: an owner dropping req at edge t SHALL still see gnt during the cycle before edge t, and gnt SHALL clear or move after edge t.
REQ-022 Requests arriving or withdrawing for non-owners during GRANT SHALL not affect the current grant.
REQ-023 gnt SHALL never have more than one bit set; sel and gnt SHALL always be consistent whenever ene=1.
REQ-024 With BURST=1, every grant SHALL last exactly 1 cycle and ownership SHALL rotate every cycle among active requesters.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL set state=IDLE, gnt=0, sel=0, ene=0, busy=0, cnt=0, last=bitNo-1, so that requester 0 has first priority.
REQ-026 Reset SHALL override all other inputs, including mid-GRANT; the first grant after reset release SHALL follow REQ-013 with the pointer at bitNo-1.

Verification
REQ-027 The bench SHALL cover: after reset, req=4'b1010 held -> gnt=0010, sel=1 for 4 cycles, then gnt=1000, sel=3 for 4 cycles, then gnt=0010 again.
REQ-028 The bench SHALL cover: req=4'b1111 constant, BURST=4 -> gnt order 0,1,2,3,0 with each grant held exactly 4 cycles and no gap between grants.
REQ-029 The bench SHALL cover: owner 2 drops req after 2 grant cycles while req[0]=1 -> after the drop edge, gnt=0001 with no IDLE cycle.
REQ-030 The bench SHALL cover: sole requester 3 held for 10 cycles, BURST=4 -> gnt=1000 continuous, with cnt restarting at 0 every 4 cycles.
REQ-031 The bench SHALL cover: rst asserted in GRANT cycle 2 with req=1111 -> next cycle gnt=0, ene=0, busy=0; after release, the first grant goes to requester 0.
REQ-032 The bench SHALL cover: random req for 10k cycles -> assert gnt is one-hot or zero, sel matches gnt, no grant exceeds BURST cycles, and no active requester waits more than (bitNo-1)*BURST+1 cycles.
